// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared constants and helpers for the registered immediate generator
//
// Purpose: immediate format codes, RV32/RV64 base opcodes, skid buffer state
//          encoding and the opcode-driven format decoder used when
//          IMM_AUTO_DECODE_EN is defined.
// Ports:   none (package).
package imm_pkg;

   localparam logic [2:0] IMM_I     = 3'b000;
   localparam logic [2:0] IMM_S     = 3'b001;
   localparam logic [2:0] IMM_B     = 3'b010;
   localparam logic [2:0] IMM_J     = 3'b011;
   localparam logic [2:0] IMM_U     = 3'b100;
   localparam logic [2:0] IMM_SHAMT = 3'b101;
   localparam logic [2:0] IMM_ZIMM  = 3'b110;
   localparam logic [2:0] IMM_ILL   = 3'b111;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'b00,
      BUF_ONE   = 2'b01,
      BUF_TWO   = 2'b10
   } buf_state_e;

   // Shift-immediate ops live inside OP-IMM and are told apart by funct3.
   function automatic logic [2:0] auto_fmt(input logic [31:0] instr);
      logic [2:0] fmt;
      case (instr[6:0])
         OPC_OP_IMM: fmt = (instr[14:12] == 3'b001 || instr[14:12] == 3'b101) ? IMM_SHAMT : IMM_I;
         OPC_LOAD,
         OPC_JALR:   fmt = IMM_I;
         OPC_STORE:  fmt = IMM_S;
         OPC_BRANCH: fmt = IMM_B;
         OPC_JAL:    fmt = IMM_J;
         OPC_LUI,
         OPC_AUIPC:  fmt = IMM_U;
         OPC_SYSTEM: fmt = IMM_ZIMM;
         default:    fmt = IMM_ILL;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/imm_extract.sv
// rtl/imm_extract.sv - combinational immediate extraction and extension
//
// Purpose: builds the XLEN-wide immediate for one instruction word.
//          With IMM_AUTO_DECODE_EN defined the format comes from the opcode
//          and fmt is ignored; otherwise fmt selects the format.
// Ports:   instr - raw instruction word
//          fmt   - format select (IMM_* code)
//          imm   - extended immediate
//          err   - format was illegal; imm is forced to zero
module imm_extract
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   input  logic [2:0]      fmt,
   output logic [XLEN-1:0] imm,
   output logic            err
);

   logic [2:0]  fmt_eff;
   logic [63:0] full;
   logic        unused_bits;

`ifdef IMM_AUTO_DECODE_EN
   assign fmt_eff     = auto_fmt(instr);
   assign unused_bits = ^fmt;
`else
   assign fmt_eff     = fmt;
   assign unused_bits = ^instr[6:0];
`endif

   // Everything is formed at 64 bits and truncated, so the U-type upper-word
   // sign fill needs no zero-width replication when XLEN is 32.
   always_comb begin
      full = 64'd0;
      err  = 1'b0;
      case (fmt_eff)
         IMM_I:     full = {{52{instr[31]}}, instr[31:20]};
         IMM_S:     full = {{52{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:     full = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_J:     full = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         IMM_U:     full = {{32{instr[31]}}, instr[31:12], 12'd0};
         IMM_SHAMT: full = (XLEN == 64) ? {58'd0, instr[25:20]} : {59'd0, instr[24:20]};
         IMM_ZIMM:  full = {59'd0, instr[19:15]};
         default:   err  = 1'b1;
      endcase
   end

   assign imm = full[XLEN-1:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with 2-entry skid buffer
//
// Purpose: accepts instructions over a valid/ready handshake, extracts the
//          immediate through imm_extract and holds up to two results in a
//          FIFO-ordered skid buffer. Optional macro: IMM_AUTO_DECODE_EN.
// Ports:   clk, rst                         - clock, synchronous active-high reset
//          in_valid/in_ready                - input handshake
//          in_instr, in_imm_src, in_tag     - instruction, format select, sideband
//          out_valid/out_ready              - output handshake
//          out_imm, out_tag, out_err        - head entry of the buffer
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_imm_src,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
);

   logic [XLEN-1:0]  new_imm;
   logic             new_err;

   buf_state_e       state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic [XLEN-1:0]  head_imm_q, head_imm_d, tail_imm_q, tail_imm_d;
   logic [TAG_W-1:0] head_tag_q, head_tag_d, tail_tag_q, tail_tag_d;
   logic             head_err_q, head_err_d, tail_err_q, tail_err_d;
   logic             in_fire, out_fire;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .instr (in_instr),
      .fmt   (in_imm_src),
      .imm   (new_imm),
      .err   (new_err)
   );

   assign in_fire  = in_valid && in_ready_q;
   assign out_fire = (state_q != BUF_EMPTY) && out_ready;

   // Head always drives the outputs; tail only fills when the head is stalled.
   always_comb begin
      state_d    = state_q;
      head_imm_d = head_imm_q;
      head_tag_d = head_tag_q;
      head_err_d = head_err_q;
      tail_imm_d = tail_imm_q;
      tail_tag_d = tail_tag_q;
      tail_err_d = tail_err_q;
      case (state_q)
         BUF_EMPTY: begin
            if (in_fire) begin
               head_imm_d = new_imm;
               head_tag_d = in_tag;
               head_err_d = new_err;
               state_d    = BUF_ONE;
            end
         end
         BUF_ONE: begin
            if (in_fire && out_fire) begin
               head_imm_d = new_imm;
               head_tag_d = in_tag;
               head_err_d = new_err;
            end else if (in_fire) begin
               tail_imm_d = new_imm;
               tail_tag_d = in_tag;
               tail_err_d = new_err;
               state_d    = BUF_TWO;
            end else if (out_fire) begin
               state_d    = BUF_EMPTY;
            end
         end
         BUF_TWO: begin
            // in_ready is low here, so only the drain path exists.
            if (out_fire) begin
               head_imm_d = tail_imm_q;
               head_tag_d = tail_tag_q;
               head_err_d = tail_err_q;
               state_d    = BUF_ONE;
            end
         end
         default: state_d = BUF_EMPTY;
      endcase
      in_ready_d = (state_d != BUF_TWO);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= BUF_EMPTY;
         in_ready_q <= 1'b1;
         head_imm_q <= '0;
         head_tag_q <= '0;
         head_err_q <= 1'b0;
         tail_imm_q <= '0;
         tail_tag_q <= '0;
         tail_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         head_imm_q <= head_imm_d;
         head_tag_q <= head_tag_d;
         head_err_q <= head_err_d;
         tail_imm_q <= tail_imm_d;
         tail_tag_q <= tail_tag_d;
         tail_err_q <= tail_err_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != BUF_EMPTY);
   assign out_imm   = head_imm_q;
   assign out_tag   = head_tag_q;
   assign out_err   = head_err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe (XLEN 32 and 64 instances)
module tb_imm_gen_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_err_a;
   logic [31:0] instr_a, out_imm_a;
   logic [2:0]  src_a;
   logic [4:0]  tag_a, out_tag_a;
   logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_err_b;
   logic [31:0] instr_b;
   logic [63:0] out_imm_b;
   logic [2:0]  src_b;
   logic [4:0]  tag_b, out_tag_b;

   imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_instr(instr_a),
      .in_imm_src(src_a), .in_tag(tag_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a),
      .out_imm(out_imm_a), .out_tag(out_tag_a), .out_err(out_err_a)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_instr(instr_b),
      .in_imm_src(src_b), .in_tag(tag_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_imm(out_imm_b), .out_tag(out_tag_b), .out_err(out_err_b)
   );

   typedef struct {
      logic [63:0] imm;
      logic [4:0]  tag;
      logic        err;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   checks = 0;
   int   errors = 0;
   bit   acc;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one input beat; the expectation is queued only if the DUT accepted it.
   task automatic send(input bit b, input logic [31:0] instr, input logic [2:0] src,
                       input logic [4:0] tag, input logic [63:0] eimm, input logic eerr,
                       output bit accepted);
      exp_t e;
      e.imm = eimm;
      e.tag = tag;
      e.err = eerr;
      if (!b) begin
         in_valid_a = 1'b1; instr_a = instr; src_a = src; tag_a = tag;
      end else begin
         in_valid_b = 1'b1; instr_b = instr; src_b = src; tag_b = tag;
      end
      @(negedge clk);
      accepted = b ? in_ready_b : in_ready_a;
      if (accepted) begin
         if (!b) q_a.push_back(e);
         else    q_b.push_back(e);
      end
      step();
      if (!b) in_valid_a = 1'b0;
      else    in_valid_b = 1'b0;
   endtask

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (!rst && out_valid_a && out_ready_a) begin
         if (q_a.size() == 0) begin
            check("a_unexpected_output", {63'd0, out_valid_a}, 64'd0);
         end else begin
            e = q_a.pop_front();
            check("a_imm", {32'd0, out_imm_a}, {32'd0, e.imm[31:0]});
            check("a_tag", {59'd0, out_tag_a}, {59'd0, e.tag});
            check("a_err", {63'd0, out_err_a}, {63'd0, e.err});
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (!rst && out_valid_b && out_ready_b) begin
         if (q_b.size() == 0) begin
            check("b_unexpected_output", {63'd0, out_valid_b}, 64'd0);
         end else begin
            e = q_b.pop_front();
            check("b_imm", out_imm_b, e.imm);
            check("b_tag", {59'd0, out_tag_b}, {59'd0, e.tag});
            check("b_err", {63'd0, out_err_b}, {63'd0, e.err});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      in_valid_a = 1'b0; instr_a = '0; src_a = '0; tag_a = '0; out_ready_a = 1'b1;
      in_valid_b = 1'b0; instr_b = '0; src_b = '0; tag_b = '0; out_ready_b = 1'b1;
      step();
      step();
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
      check("rst_in_ready",  {63'd0, in_ready_a},  64'd1);
      check("rst_out_imm",   {32'd0, out_imm_a},   64'd0);
      check("rst_out_tag",   {59'd0, out_tag_a},   64'd0);
      check("rst_out_err",   {63'd0, out_err_a},   64'd0);
      check("rst_b_valid",   {63'd0, out_valid_b}, 64'd0);
      step();

      // I-type with one-cycle latency
      send(0, 32'hFFF00093, 3'b000, 5'd1, 64'hFFFFFFFF, 1'b0, acc);
      check("i_accepted", {63'd0, acc}, 64'd1);
      @(negedge clk);
      check("i_latency_valid", {63'd0, out_valid_a}, 64'd1);
      step();

      // S then B on consecutive cycles
      send(0, 32'hFE20AE23, 3'b001, 5'd2, 64'hFFFFFFFC, 1'b0, acc);
      check("s_accepted", {63'd0, acc}, 64'd1);
      send(0, 32'h00000463, 3'b010, 5'd3, 64'h00000008, 1'b0, acc);
      check("b_accepted", {63'd0, acc}, 64'd1);
      @(negedge clk);
      check("sb_no_bubble", {63'd0, out_valid_a}, 64'd1);
      step();
      step();

      // SHAMT at XLEN=32 keeps only i[24:20]; illegal format
      send(0, 32'h03F00013, 3'b101, 5'd4, 64'd31, 1'b0, acc);
      send(0, 32'hFFFFFFFF, 3'b111, 5'd5, 64'd0, 1'b1, acc);
      step();
      step();

      // Back-pressure: J and U fill the buffer, third beat is refused
      out_ready_a = 1'b0;
      send(0, 32'h001000EF, 3'b011, 5'd6, 64'h00000800, 1'b0, acc);
      check("j_accepted", {63'd0, acc}, 64'd1);
      send(0, 32'h123450B7, 3'b100, 5'd7, 64'h12345000, 1'b0, acc);
      check("u_accepted", {63'd0, acc}, 64'd1);
      check("bp_in_ready_low", {63'd0, in_ready_a}, 64'd0);
      send(0, 32'h000F8073, 3'b110, 5'd8, 64'd31, 1'b0, acc);
      check("bp_refused", {63'd0, acc}, 64'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_hold_valid", {63'd0, out_valid_a}, 64'd1);
         check("bp_hold_imm",   {32'd0, out_imm_a},   64'h800);
         check("bp_hold_tag",   {59'd0, out_tag_a},   64'd6);
      end
      step();
      out_ready_a = 1'b1;
      repeat (3) step();
      check("bp_drained", q_a.size(), 64'd0);
      check("bp_in_ready_back", {63'd0, in_ready_a}, 64'd1);

      // ZIMM
      send(0, 32'h000F8073, 3'b110, 5'd8, 64'd31, 1'b0, acc);
      step();
      step();

      // Reset with the buffer full discards both entries
      out_ready_a = 1'b0;
      send(0, 32'h00100093, 3'b000, 5'd9,  64'd1, 1'b0, acc);
      send(0, 32'h00200093, 3'b000, 5'd10, 64'd2, 1'b0, acc);
      check("full_in_ready", {63'd0, in_ready_a}, 64'd0);
      q_a.delete();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_valid",    {63'd0, out_valid_a}, 64'd0);
      check("mid_rst_in_ready", {63'd0, in_ready_a},  64'd1);
      out_ready_a = 1'b1;
      repeat (4) step();
      check("mid_rst_no_stale", {63'd0, out_valid_a}, 64'd0);

      // XLEN=64 instance
      send(1, 32'h800000B7, 3'b100, 5'd1, 64'hFFFFFFFF80000000, 1'b0, acc);
      send(1, 32'h03F00013, 3'b101, 5'd2, 64'd63, 1'b0, acc);
      send(1, 32'hFFF00093, 3'b000, 5'd3, 64'hFFFFFFFFFFFFFFFF, 1'b0, acc);
      send(1, 32'h12345678, 3'b111, 5'd4, 64'd0, 1'b1, acc);
      repeat (3) step();
      check("b_drained", q_b.size(), 64'd0);
      check("a_drained", q_a.size(), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
